// File: rtl/chime_pkg.sv
// Shared types and constants for the cuckoo chime scheduler.
package chime_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STRIKE = 2'd1,
        GAP    = 2'd2
    } chime_state_t;

    localparam int MAX_STRIKES = 12;
    localparam int HALF_MINUTE = 30;

    typedef logic [3:0] strike_cnt_t;

    // 12-hour dial: hours 0 and 12 both strike twelve times.
    function automatic strike_cnt_t strike_count(input logic [4:0] hour);
        logic [4:0] dial;
        dial = (hour >= 5'd12) ? hour - 5'd12 : hour;
        if (dial == 5'd0) begin
            return strike_cnt_t'(MAX_STRIKES);
        end
        return dial[3:0];
    endfunction

endpackage

// File: rtl/chime_scheduler_if.sv
// Time-of-day inputs, user controls and strike outputs of the chime scheduler.
interface chime_scheduler_if;
    import chime_pkg::*;

    logic        sec_tick;
    logic [4:0]  hour;
    logic [5:0]  minute;
    logic [5:0]  second;
    logic        mute;
    logic        test_chime;
    logic        play_sound;
    logic        busy;
    strike_cnt_t strikes_left;

    modport master (
        output sec_tick, hour, minute, second, mute, test_chime,
        input  play_sound, busy, strikes_left
    );

    modport slave (
        input  sec_tick, hour, minute, second, mute, test_chime,
        output play_sound, busy, strikes_left
    );

endinterface

// File: rtl/chime_gap_timer.sv
// Loadable down-counter timing the interval between two strike pulses.
module chime_gap_timer #(
    parameter int STRIKE_GAP = 200_000_000
) (
    input  logic clk_sys,
    input  logic rst_b,
    input  logic load,
    input  logic dec,
    output logic zero
);

    localparam int CNT_W = (STRIKE_GAP < 2) ? 1 : $clog2(STRIKE_GAP);
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(STRIKE_GAP - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = LOAD_VAL;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Flags the cycle in which the count reaches zero, so the caller can
    // act on it without spending an extra cycle at zero.
    assign zero = (count_d == '0);

    always_ff @(posedge clk_sys) begin
        if (!rst_b) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/chime_scheduler.sv
// Hourly / half-hourly / test strike sequencer for the cuckoo sound stage.
module chime_scheduler
    import chime_pkg::*;
#(
    parameter int STRIKE_GAP   = 200_000_000,
    parameter bit HALF_HOUR_EN = 1'b1
) (
    input  logic             CLOCK_50,
    input  logic             RESET_N,
    chime_scheduler_if.slave bus
);

    // state  | meaning
    // IDLE   | waiting for an hour, half-hour or test request
    // STRIKE | play_sound high for this single cycle, gap timer loaded
    // GAP    | gap timer running; next strike or back to IDLE on expiry

    if (STRIKE_GAP < 2) begin : g_gap_check
        $error("chime_scheduler: STRIKE_GAP must be at least 2");
    end

    chime_state_t state_q, state_d;
    logic         play_sound_q, play_sound_d;
    logic         busy_q, busy_d;
    strike_cnt_t  strikes_left_q, strikes_left_d;
    logic         test_prev_q, test_prev_d;

    logic top_req, half_req, test_req;
    logic timer_load, timer_dec, timer_zero;

    assign top_req  = bus.sec_tick && (bus.minute == 6'd0) && (bus.second == 6'd0)
                      && (bus.hour <= 5'd23);
    assign half_req = HALF_HOUR_EN && bus.sec_tick && (bus.second == 6'd0)
                      && (bus.minute == 6'(HALF_MINUTE));
    assign test_req = bus.test_chime && !test_prev_q;

    assign timer_load = (state_q == STRIKE);
    assign timer_dec  = (state_q == GAP);

    chime_gap_timer #(
        .STRIKE_GAP(STRIKE_GAP)
    ) u_gap_timer (
        .clk_sys(CLOCK_50),
        .rst_b  (RESET_N),
        .load   (timer_load),
        .dec    (timer_dec),
        .zero   (timer_zero)
    );

    always_comb begin
        state_d        = state_q;
        strikes_left_d = strikes_left_q;
        test_prev_d    = bus.test_chime;
        case (state_q)
            IDLE: begin
                if (!bus.mute) begin
                    if (top_req) begin
                        strikes_left_d = strike_count(bus.hour);
                        state_d        = STRIKE;
                    end else if (half_req || test_req) begin
                        strikes_left_d = 4'd1;
                        state_d        = STRIKE;
                    end
                end
            end
            STRIKE: begin
                if (bus.mute) begin
                    strikes_left_d = '0;
                    state_d        = IDLE;
                end else begin
                    state_d = GAP;
                end
            end
            GAP: begin
                if (bus.mute) begin
                    strikes_left_d = '0;
                    state_d        = IDLE;
                end else if (timer_zero) begin
                    strikes_left_d = strikes_left_q - 4'd1;
                    state_d        = (strikes_left_q != 4'd1) ? STRIKE : IDLE;
                end
            end
            default: begin
                strikes_left_d = '0;
                state_d        = IDLE;
            end
        endcase
        // Outputs are registered copies of the next state so they line up with it.
        play_sound_d = (state_d == STRIKE);
        busy_d       = (state_d != IDLE);
    end

    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            state_q        <= IDLE;
            play_sound_q   <= 1'b0;
            busy_q         <= 1'b0;
            strikes_left_q <= '0;
            test_prev_q    <= 1'b1;
        end else begin
            state_q        <= state_d;
            play_sound_q   <= play_sound_d;
            busy_q         <= busy_d;
            strikes_left_q <= strikes_left_d;
            test_prev_q    <= test_prev_d;
        end
    end

    assign bus.play_sound   = play_sound_q;
    assign bus.busy         = busy_q;
    assign bus.strikes_left = strikes_left_q;

endmodule

// File: tb/tb_chime_scheduler.sv
// Scoreboard bench for chime_scheduler: two instances, with and without half-hour strikes.
module tb_chime_scheduler;
    import chime_pkg::*;

    localparam int GAP_CYC = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sec_tick;
    logic [4:0] hour;
    logic [5:0] minute;
    logic [5:0] second;
    logic       mute;
    logic       test_chime;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int exp_q[$];
    int exp_nh_q[$];

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    chime_scheduler_if bus ();
    chime_scheduler_if bus_nh ();

    assign bus.sec_tick      = sec_tick;
    assign bus.hour          = hour;
    assign bus.minute        = minute;
    assign bus.second        = second;
    assign bus.mute          = mute;
    assign bus.test_chime    = test_chime;
    assign bus_nh.sec_tick   = sec_tick;
    assign bus_nh.hour       = hour;
    assign bus_nh.minute     = minute;
    assign bus_nh.second     = second;
    assign bus_nh.mute       = mute;
    assign bus_nh.test_chime = test_chime;

    chime_scheduler #(.STRIKE_GAP(GAP_CYC), .HALF_HOUR_EN(1'b1)) dut (
        .CLOCK_50(clk),
        .RESET_N (rst_n),
        .bus     (bus)
    );

    chime_scheduler #(.STRIKE_GAP(GAP_CYC), .HALF_HOUR_EN(1'b0)) dut_nh (
        .CLOCK_50(clk),
        .RESET_N (rst_n),
        .bus     (bus_nh)
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Every strike pulse must match the next expected cycle number.
    always @(negedge clk) begin
        if (bus.play_sound) begin
            if (exp_q.size() == 0) check("dut_unexpected_pulse", cyc, -1);
            else                   check("dut_pulse_cycle", cyc, exp_q.pop_front());
        end
        if (bus_nh.play_sound) begin
            if (exp_nh_q.size() == 0) check("nh_unexpected_pulse", cyc, -1);
            else                      check("nh_pulse_cycle", cyc, exp_nh_q.pop_front());
        end
    end

    task automatic fire(input int h, input int m, input int s, input int n, input int n_nh,
                        input bit with_test, output int base);
        @(negedge clk);
        hour     = 5'(h);
        minute   = 6'(m);
        second   = 6'(s);
        sec_tick = 1'b1;
        if (with_test) test_chime = 1'b1;
        base = cyc + 1;
        for (int i = 0; i < n; i++)    exp_q.push_back(base + GAP_CYC * i);
        for (int i = 0; i < n_nh; i++) exp_nh_q.push_back(base + GAP_CYC * i);
        @(negedge clk);
        sec_tick = 1'b0;
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || exp_nh_q.size() != 0 || bus.busy || bus_nh.busy) && t < 400) begin
            @(negedge clk);
            t++;
        end
        check("drain_in_time", int'(t < 400), 1);
        check("dut_missing_pulses", exp_q.size(), 0);
        check("nh_missing_pulses", exp_nh_q.size(), 0);
        exp_q.delete();
        exp_nh_q.delete();
        repeat (12) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        rst_n      = 1'b0;
        sec_tick   = 1'b0;
        hour       = '0;
        minute     = 6'd15;
        second     = 6'd7;
        mute       = 1'b0;
        test_chime = 1'b1;

        repeat (4) @(negedge clk);
        check("rst_play", int'(bus.play_sound), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_strikes", int'(bus.strikes_left), 0);
        check("rst_nh_busy", int'(bus_nh.busy), 0);
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        check("held_button_no_busy", int'(bus.busy), 0);
        test_chime = 1'b0;
        @(negedge clk);

        // hour 15 -> 3 strikes
        fire(15, 0, 0, 3, 3, 1'b0, base);
        check("h15_play_first", int'(bus.play_sound), 1);
        check("h15_strikes_first", int'(bus.strikes_left), 3);
        check("h15_busy", int'(bus.busy), 1);
        wait_cyc(base + GAP_CYC);
        check("h15_strikes_second", int'(bus.strikes_left), 2);
        wait_cyc(base + 3 * GAP_CYC - 1);
        check("h15_busy_before_end", int'(bus.busy), 1);
        wait_cyc(base + 3 * GAP_CYC);
        check("h15_busy_end", int'(bus.busy), 0);
        check("h15_strikes_end", int'(bus.strikes_left), 0);
        drain();

        // midnight -> 12 strikes
        fire(0, 0, 0, 12, 12, 1'b0, base);
        check("h0_strikes", int'(bus.strikes_left), 12);
        drain();

        // half hour -> 1 strike, none when disabled
        fire(0, 30, 0, 1, 0, 1'b0, base);
        check("half_strikes", int'(bus.strikes_left), 1);
        check("half_nh_busy", int'(bus_nh.busy), 0);
        drain();

        // out-of-range hour ignored
        fire(25, 0, 0, 0, 0, 1'b0, base);
        check("h25_busy", int'(bus.busy), 0);
        drain();

        // test button edge alone -> 1 strike
        @(negedge clk);
        test_chime = 1'b1;
        base = cyc + 1;
        exp_q.push_back(base);
        exp_nh_q.push_back(base);
        @(negedge clk);
        check("test_strikes", int'(bus.strikes_left), 1);
        test_chime = 1'b0;
        drain();

        // mute three cycles after the second of five strikes
        fire(5, 0, 0, 2, 2, 1'b0, base);
        wait_cyc(base + GAP_CYC + 3);
        check("mute_strikes_before", int'(bus.strikes_left), 4);
        mute = 1'b1;
        @(negedge clk);
        check("mute_busy", int'(bus.busy), 0);
        check("mute_strikes", int'(bus.strikes_left), 0);
        check("mute_play", int'(bus.play_sound), 0);

        // request while muted is discarded
        fire(5, 0, 0, 0, 0, 1'b0, base);
        check("muted_req_busy", int'(bus.busy), 0);
        repeat (3) @(negedge clk);
        check("muted_req_busy_later", int'(bus.busy), 0);
        mute = 1'b0;
        drain();

        // test edge during an hour-2 sequence is dropped
        fire(2, 0, 0, 2, 2, 1'b0, base);
        wait_cyc(base + 3);
        test_chime = 1'b1;
        @(negedge clk);
        test_chime = 1'b0;
        drain();

        // test edge together with top-of-hour: hour count wins
        fire(4, 0, 0, 4, 4, 1'b1, base);
        check("prio_strikes", int'(bus.strikes_left), 4);
        drain();
        test_chime = 1'b0;
        repeat (3) @(negedge clk);

        // reset in the gap after the first of seven strikes
        fire(7, 0, 0, 1, 1, 1'b0, base);
        check("h7_strikes", int'(bus.strikes_left), 7);
        wait_cyc(base + 2);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("midrst_play", int'(bus.play_sound), 0);
        check("midrst_busy", int'(bus.busy), 0);
        check("midrst_strikes", int'(bus.strikes_left), 0);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        check("after_rst_busy", int'(bus.busy), 0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
